// File: rtl/cacheline_adapter.sv
// Cache line adapter: turns one 256-bit line read/write into a 4-beat
// 64-bit burst toward physical memory and pulses resp_o when finished.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   line_i / line_o     write-back line in, assembled fill line out
//   address_i, read_i,
//   write_i, resp_o     cache-side request and completion pulse
//   burst_i / burst_o   read beat in, write beat out
//   address_o, read_o,
//   write_o, resp_i     memory-side burst request and beat ack
module cacheline_adapter #(
   parameter int s_line    = 256,
   parameter int s_burst   = 64,
   parameter int burst_len = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [s_line-1:0]    line_i,
   output logic [s_line-1:0]    line_o,
   input  logic [31:0]          address_i,
   input  logic                 read_i,
   input  logic                 write_i,
   output logic                 resp_o,
   input  logic [s_burst-1:0]   burst_i,
   output logic [s_burst-1:0]   burst_o,
   output logic [31:0]          address_o,
   output logic                 read_o,
   output logic                 write_o,
   input  logic                 resp_i
);

   localparam int CNT_W = $clog2(burst_len);
   // byte-offset bits inside one line; forced to zero on the burst address
   localparam int OFS_W = $clog2(s_line / 8);

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [s_line-1:0]   buf_q, buf_d;

   logic                last_beat;

   assign last_beat = resp_i && (cnt_q == CNT_W'(burst_len - 1));

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; read wins when both requests are raised
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (read_i) begin
               state_d = RD_BURST;
            end else if (write_i) begin
               state_d = WR_BURST;
            end
         end
         RD_BURST: begin
            if (last_beat) state_d = DONE;
         end
         WR_BURST: begin
            if (last_beat) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         addr_q <= '0;
         buf_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         buf_q  <= buf_d;
      end
   end

   // all request data is captured in IDLE; later changes are ignored
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      buf_d  = buf_q;
      unique case (state_q)
         IDLE: begin
            if (read_i || write_i) begin
               addr_d = {address_i[31:OFS_W], OFS_W'(0)};
               cnt_d  = '0;
            end
            if (!read_i && write_i) begin
               buf_d = line_i;
            end
         end
         RD_BURST: begin
            if (resp_i) begin
               buf_d[int'(cnt_q)*s_burst +: s_burst] = burst_i;
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_BURST: begin
            if (resp_i) cnt_d = cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   // outputs
   always_comb begin
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      address_o = '0;
      burst_o   = '0;
      unique case (state_q)
         RD_BURST: begin
            read_o    = 1'b1;
            address_o = addr_q;
         end
         WR_BURST: begin
            write_o   = 1'b1;
            address_o = addr_q;
            burst_o   = buf_q[int'(cnt_q)*s_burst +: s_burst];
         end
         DONE: resp_o = 1'b1;
         default: ;
      endcase
   end

   assign line_o = buf_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios plus
// randomized bursts compared against a transaction-level model.
module tb_cacheline_adapter;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [255:0]  line_i = '0;
   logic [255:0]  line_o;
   logic [31:0]   address_i = '0;
   logic          read_i = 1'b0;
   logic          write_i = 1'b0;
   logic          resp_o;
   logic [63:0]   burst_i = '0;
   logic [63:0]   burst_o;
   logic [31:0]   address_o;
   logic          read_o;
   logic          write_o;
   logic          resp_i = 1'b0;

   int checks = 0;
   int errors = 0;

   // model of what line_o should currently show
   logic [255:0]  model_line = '0;

   always #5 clk = ~clk;

   cacheline_adapter dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Drives one transaction from IDLE through DONE and back to IDLE,
   // tallying deviations from the expected bus behaviour.
   task automatic do_txn(
      input  bit              rd,
      input  bit              wr,
      input  logic [31:0]     addr,
      input  logic [255:0]    wline,
      input  logic [3:0][63:0] beats,
      input  logic [3:0][7:0] gaps,
      output int              lat,
      output int              bad_ctl,
      output int              bad_addr,
      output int              bad_data,
      output logic [63:0]     first_bo
   );
      bit          is_rd;
      bit          is_wr;
      logic [31:0] exp_a;
      int          edges;
      int          extra;
      is_rd    = rd;
      is_wr    = !rd && wr;
      exp_a    = addr - (addr % 32);
      bad_ctl  = 0;
      bad_addr = 0;
      bad_data = 0;
      first_bo = '0;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wline;
      resp_i    = 1'b0;
      step();
      edges = 1;
      first_bo = burst_o;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g <= int'(gaps[k]); g++) begin
            if (read_o !== is_rd || write_o !== is_wr || resp_o !== 1'b0)
               bad_ctl++;
            if (address_o !== exp_a) bad_addr++;
            if (is_wr && burst_o !== wline[64*k +: 64]) bad_data++;
            resp_i    = (g == int'(gaps[k]));
            burst_i   = resp_i ? beats[k] : rand64();
            address_i = $urandom;
            line_i    = rand256();
            step();
            edges++;
         end
      end
      resp_i = 1'b0;
      extra  = 0;
      while (resp_o !== 1'b1 && extra < 8) begin
         step();
         edges++;
         extra++;
      end
      lat = (resp_o === 1'b1) ? edges + 1 : -1;
      if (read_o !== 1'b0 || write_o !== 1'b0) bad_ctl++;
      read_i  = 1'b0;
      write_i = 1'b0;
      step();
      if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0)
         bad_ctl++;
      if (is_rd) begin
         for (int k = 0; k < 4; k++) model_line[64*k +: 64] = beats[k];
      end else if (is_wr) begin
         model_line = wline;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if ({line_o, resp_o, read_o, write_o, burst_o, address_o} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs nonzero during reset line=%h ctl=%b%b%b",
                     line_o, resp_o, read_o, write_o);
         end
      end
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         resp_i  = 1'($urandom);
         burst_i = rand64();
         step();
         checks++;
         if ({line_o, resp_o, read_o, write_o, burst_o, address_o} !== '0) begin
            errors++;
            $display("FAIL idle_quiet: cycle %0d outputs nonzero ctl=%b%b%b addr=%h",
                     c, resp_o, read_o, write_o, address_o);
         end
      end
      resp_i = 1'b0;
      model_line = '0;
   endtask

   task automatic test_read();
      logic [3:0][63:0] beats;
      int lat, bc, ba, bd;
      logic [63:0] fb;
      beats[0] = {16{4'h1}};
      beats[1] = {16{4'h2}};
      beats[2] = {16{4'h3}};
      beats[3] = {16{4'h4}};
      do_txn(1'b1, 1'b0, 32'h0000_1234, rand256(), beats, '0,
             lat, bc, ba, bd, fb);
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL read_latency: got %0d want 6", lat);
      end
      checks++;
      if (ba !== 0) begin
         errors++;
         $display("FAIL read_addr: %0d cycles address_o != 00001220", ba);
      end
      checks++;
      if (bc !== 0) begin
         errors++;
         $display("FAIL read_ctl: %0d bad control cycles", bc);
      end
      checks++;
      if (line_o !== {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}) begin
         errors++;
         $display("FAIL read_line: got %h", line_o);
      end
   endtask

   task automatic test_write_stalls();
      logic [255:0] wl;
      logic [3:0][7:0] gaps;
      int lat, bc, ba, bd;
      logic [63:0] fb;
      wl = 256'h0123_4567_89ab_cdef_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc;
      // ack pattern 1,0,0,1,1,0,1
      gaps[0] = 8'd0;
      gaps[1] = 8'd2;
      gaps[2] = 8'd0;
      gaps[3] = 8'd1;
      do_txn(1'b0, 1'b1, 32'hDEAD_BEEF, wl, '0, gaps, lat, bc, ba, bd, fb);
      checks++;
      if (bd !== 0) begin
         errors++;
         $display("FAIL write_beats: %0d cycles burst_o wrong", bd);
      end
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL write_latency: got %0d want 9", lat);
      end
      checks++;
      if (bc !== 0) begin
         errors++;
         $display("FAIL write_ctl: %0d bad control cycles", bc);
      end
      checks++;
      if (ba !== 0) begin
         errors++;
         $display("FAIL write_addr: %0d cycles address_o != deadbee0", ba);
      end
      checks++;
      if (line_o !== wl) begin
         errors++;
         $display("FAIL write_line: got %h want %h", line_o, wl);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0][63:0] beats;
      logic [255:0] exp;
      int lat, bc, ba, bd;
      logic [63:0] fb;
      for (int k = 0; k < 4; k++) beats[k] = rand64();
      do_txn(1'b1, 1'b1, 32'h0000_8040, rand256(), beats, '0,
             lat, bc, ba, bd, fb);
      for (int k = 0; k < 4; k++) exp[64*k +: 64] = beats[k];
      checks++;
      if (bc !== 0) begin
         errors++;
         $display("FAIL both_req_ctl: %0d cycles not pure read", bc);
      end
      checks++;
      if (line_o !== exp) begin
         errors++;
         $display("FAIL both_req_line: got %h want %h", line_o, exp);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [3:0][63:0] beats;
      logic [255:0] exp;
      int lat, bc, ba, bd;
      logic [63:0] fb;
      read_i    = 1'b1;
      address_i = 32'h0000_4000;
      step();
      for (int k = 0; k < 2; k++) begin
         resp_i  = 1'b1;
         burst_i = rand64();
         step();
      end
      resp_i = 1'b0;
      rst    = 1'b0;
      #1;
      checks++;
      if (read_o !== 1'b0 || line_o !== '0 || resp_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: read_o=%b resp_o=%b line=%h", read_o, resp_o, line_o);
      end
      read_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (resp_o !== 1'b0 || read_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: resp_o=%b read_o=%b", resp_o, read_o);
         end
      end
      rst = 1'b1;
      step();
      model_line = '0;
      for (int k = 0; k < 4; k++) beats[k] = rand64();
      do_txn(1'b1, 1'b0, 32'h0000_401F, '0, beats, '0, lat, bc, ba, bd, fb);
      for (int k = 0; k < 4; k++) exp[64*k +: 64] = beats[k];
      checks++;
      if (line_o !== exp || lat !== 6 || bc !== 0 || ba !== 0) begin
         errors++;
         $display("FAIL post_reset_read: lat=%0d ctl=%0d addr=%0d line=%h",
                  lat, bc, ba, line_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][63:0] beats;
      logic [255:0] wl;
      int lat, bc, ba, bd;
      logic [63:0] fb;
      for (int k = 0; k < 4; k++) beats[k] = rand64();
      do_txn(1'b1, 1'b0, 32'h0001_0000, '0, beats, '0, lat, bc, ba, bd, fb);
      wl = rand256();
      do_txn(1'b0, 1'b1, 32'h0001_0020, wl, '0, '0, lat, bc, ba, bd, fb);
      checks++;
      if (fb !== wl[63:0]) begin
         errors++;
         $display("FAIL b2b_first_beat: got %h want %h", fb, wl[63:0]);
      end
      checks++;
      if (bd !== 0 || bc !== 0 || lat !== 6) begin
         errors++;
         $display("FAIL b2b_write: data=%0d ctl=%0d lat=%0d", bd, bc, lat);
      end
   endtask

   task automatic test_random();
      logic [3:0][63:0] beats;
      logic [3:0][7:0] gaps;
      logic [255:0] wl;
      logic [31:0] addr;
      bit rd, wr;
      int lat, bc, ba, bd, exp_lat;
      logic [63:0] fb;
      for (int t = 0; t < 25; t++) begin
         rd = 1'($urandom);
         wr = rd ? 1'($urandom) : 1'b1;
         addr = $urandom;
         wl = rand256();
         exp_lat = 6;
         for (int k = 0; k < 4; k++) begin
            beats[k] = rand64();
            gaps[k]  = 8'($urandom_range(0, 3));
            exp_lat += int'(gaps[k]);
         end
         do_txn(rd, wr, addr, wl, beats, gaps, lat, bc, ba, bd, fb);
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL rnd_latency: txn %0d got %0d want %0d", t, lat, exp_lat);
         end
         checks++;
         if (bc !== 0 || ba !== 0 || bd !== 0) begin
            errors++;
            $display("FAIL rnd_bus: txn %0d ctl=%0d addr=%0d data=%0d", t, bc, ba, bd);
         end
         checks++;
         if (line_o !== model_line) begin
            errors++;
            $display("FAIL rnd_line: txn %0d got %h want %h", t, line_o, model_line);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_stalls();
      test_simultaneous();
      test_reset_mid_read();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Sits directly downstream of the cache datapath, between the cache's 256-bit line port (pmem_* side) and the 64-bit burst physical memory.
- Converts one 256-bit line read or write into a 4-beat 64-bit burst transaction.
- Returns a single-cycle completion pulse to the cache controller.

Parameters:
s_line, 256, cache line width in bits
s_burst, 64, memory beat width in bits
burst_len, 4, beats per line (s_line / s_burst)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
line_i  input  256  write-back line from cache (pmem_wdata)
line_o  output  256  assembled fill line to cache (pmem_rdata)
address_i  input  32  line address from cache (pmem_address)
read_i  input  1  cache requests line fill
write_i  input  1  cache requests line write-back
resp_o  output  1  one-cycle completion pulse to cache (pmem_resp)
burst_i  input  64  read beat from memory
burst_o  output  64  write beat to memory
address_o  output  32  burst base address to memory
read_o  output  1  memory read request
write_o  output  1  memory write request
resp_i  input  1  memory beat acknowledge

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, beat counter=0, line buffer=0.
  - Outputs on reset: line_o=0, resp_o=0, read_o=0, write_o=0, burst_o=0, address_o=0.
  - Reset asserted mid-burst aborts immediately. No resp_o is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - read_i=1: latch address_i with bits [4:0] forced to 0, clear counter, go RD_BURST.
  - write_i=1 (read_i=0): latch address_i the same way, latch line_i into line buffer, clear counter, go WR_BURST.
  - read_i and write_i both high: read wins, write ignored.
- RD_BURST:
  - read_o=1 and address_o=latched address, held for the whole burst.
  - Each cycle with resp_i=1: line buffer bits [64*cnt+63 : 64*cnt] <= burst_i; cnt increments.
  - On the resp_i where cnt=3: go DONE.
- WR_BURST:
  - write_o=1, address_o=latched address.
  - burst_o = line buffer slice [64*cnt+63 : 64*cnt] (combinational from cnt).
  - Each resp_i=1 increments cnt. On the resp_i where cnt=3: go DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0. Next state is IDLE unconditionally.
  - The controller drops read_i/write_i on the edge it samples resp_o, so IDLE sees no stale request.
- line_o drives the line buffer continuously.
  - After a read it holds the fill line until the next read or write transaction overwrites the buffer.
  - A write also loads the buffer, so line_o then shows the written line.
- Latency: read/write request to resp_o = (cycles to collect 4 resp_i) + 2. The minimum is 6 cycles: 1 IDLE, 4 beats, 1 DONE.
- Beat gaps: resp_i=0 cycles inside a burst stall. Counter and outputs hold; there is no timeout.
- resp_i in IDLE or DONE is ignored.
- Request changes mid-burst (read_i/write_i/address_i/line_i) are ignored. All transaction data is latched in IDLE.
- read_o and write_o are never both 1.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high, no requests → all outputs 0 and stay 0; resp_i pulses are ignored.
- Back-to-back read: address_i=0x0000_1234, read_i=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles.
  - Required: address_o=0x0000_1220 throughout.
  - Required: resp_o high exactly at cycle 6 after request.
  - Required: line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with stalls: line_i=256'h0123…(distinct beats), write_i=1, resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o steps beat0→beat3, holding through gaps.
  - Required: write_o stays high until the 4th ack, then resp_o is one pulse and write_o=0.
- Simultaneous read_i=write_i=1 in IDLE → read burst only; write_o never asserted.
- Reset mid-read: rst low after 2 beats accepted → read_o=0 and line_o=0 immediately; no resp_o. A subsequent full read completes normally with correct data.
- Read then immediate write: issue a write the cycle after resp_o → new burst starts with cnt=0; first burst_o is line_i[63:0].
